// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller front end.
// Floor sizing defaults and the scheduler direction encoding.
package elevator_pkg;

    localparam int unsigned MAX_FLOORS  = 16;
    localparam int unsigned FLOOR_IDX_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } dir_state_e;

endpackage

// File: rtl/call_sync_edge.sv
// Per-bit two-flop synchroniser followed by a rising-edge pulse.
// Used for raw call/door buttons arriving from the asynchronous panel.
module call_sync_edge #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches call requests and picks the next target floor with a SCAN policy.
// Also masks targets during door dwell and requests a door open for local calls.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS   = MAX_FLOORS,
    parameter int unsigned FLOOR_W      = FLOOR_IDX_W,
    parameter int unsigned DWELL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_buttons,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    input  logic                  moving_up,
    input  logic                  moving_down,
    output logic [NUM_FLOORS-1:0] floor_buttons,
    output logic                  door_open_req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  dir_down
);

    localparam logic [FLOOR_W-1:0]    TopFloor  = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [7:0]            DwellLoad = 8'(DWELL_CYCLES);
    localparam logic [NUM_FLOORS-1:0] OneBit    = {{(NUM_FLOORS - 1){1'b0}}, 1'b1};

    // Lowest set bit strictly above floor cf, as a one-hot.
    function automatic logic [NUM_FLOORS-1:0] nearest_above(
        input logic [NUM_FLOORS-1:0] map,
        input logic [FLOOR_W-1:0]    cf
    );
        logic [NUM_FLOORS-1:0] oh;
        oh = '0;
        for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
            if (map[i] && (i > int'(cf))) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    // Highest set bit strictly below floor cf, as a one-hot.
    function automatic logic [NUM_FLOORS-1:0] nearest_below(
        input logic [NUM_FLOORS-1:0] map,
        input logic [FLOOR_W-1:0]    cf
    );
        logic [NUM_FLOORS-1:0] oh;
        oh = '0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (map[i] && (i < int'(cf))) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    dir_state_e            state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] floor_buttons_q, floor_buttons_d;
    logic                  door_open_req_q, door_open_req_d;
    logic [7:0]            dwell_q, dwell_d;
    logic                  door_q;

    logic [NUM_FLOORS-1:0] call_rise;
    logic [FLOOR_W-1:0]    cf;
    logic [NUM_FLOORS-1:0] floor_oh;
    logic [NUM_FLOORS-1:0] pend_eff;
    logic [NUM_FLOORS-1:0] above_oh, below_oh, target_oh;
    logic                  above, below;

    call_sync_edge #(
        .WIDTH (NUM_FLOORS)
    ) u_call_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (call_buttons),
        .rise     (call_rise)
    );

    // Out-of-range floor reports collapse onto the top floor.
    assign cf       = (current_floor > TopFloor) ? TopFloor : current_floor;
    assign floor_oh = OneBit << cf;
    assign pend_eff = pending_q & ~floor_oh;
    assign above_oh = nearest_above(pend_eff, cf);
    assign below_oh = nearest_below(pend_eff, cf);
    assign above    = |above_oh;
    assign below    = |below_oh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (above) begin
                    state_d = S_UP;
                end else if (below) begin
                    state_d = S_DOWN;
                end
            end
            S_UP: begin
                if (!above) begin
                    state_d = below ? S_DOWN : S_IDLE;
                end
            end
            S_DOWN: begin
                if (!below) begin
                    state_d = above ? S_UP : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Never turn around against the car's current motion.
        if ((state_d == S_UP && moving_down) || (state_d == S_DOWN && moving_up)) begin
            state_d = state_q;
        end
    end

    always_comb begin
        dir_up   = (state_q == S_UP);
        dir_down = (state_q == S_DOWN);
    end

    always_comb begin
        target_oh = '0;
        unique case (state_q)
            S_UP:    target_oh = above_oh;
            S_DOWN:  target_oh = below_oh;
            default: target_oh = '0;
        endcase

        dwell_d = dwell_q;
        if (door_open && !door_q) begin
            dwell_d = DwellLoad;
        end else if (!door_open) begin
            dwell_d = '0;
        end else if (dwell_q != 8'd0) begin
            dwell_d = dwell_q - 8'd1;
        end

        // A clear at the open door wins over a simultaneous new press.
        pending_d       = (pending_q | call_rise) & ~(door_open ? floor_oh : '0);
        floor_buttons_d = (dwell_d != 8'd0) ? '0 : target_oh;
        door_open_req_d = pending_q[cf] & ~door_open & ~moving_up & ~moving_down;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q       <= '0;
            floor_buttons_q <= '0;
            door_open_req_q <= 1'b0;
            dwell_q         <= 8'd0;
            door_q          <= 1'b0;
        end else begin
            pending_q       <= pending_d;
            floor_buttons_q <= floor_buttons_d;
            door_open_req_q <= door_open_req_d;
            dwell_q         <= dwell_d;
            door_q          <= door_open;
        end
    end

    assign pending       = pending_q;
    assign floor_buttons = floor_buttons_q;
    assign door_open_req = door_open_req_q;

`ifndef SYNTHESIS
    floor_buttons_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(floor_buttons));
`endif

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler with hand-computed expectations.
module tb_elevator_call_scheduler;

    logic        clk;
    logic        reset;
    logic [15:0] call_buttons;
    logic [3:0]  current_floor;
    logic        door_open;
    logic        moving_up;
    logic        moving_down;
    logic [15:0] floor_buttons;
    logic        door_open_req;
    logic [15:0] pending;
    logic        dir_up;
    logic        dir_down;

    int checks = 0;
    int errors = 0;

    elevator_call_scheduler #(
        .NUM_FLOORS   (16),
        .FLOOR_W      (4),
        .DWELL_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .call_buttons  (call_buttons),
        .current_floor (current_floor),
        .door_open     (door_open),
        .moving_up     (moving_up),
        .moving_down   (moving_down),
        .floor_buttons (floor_buttons),
        .door_open_req (door_open_req),
        .pending       (pending),
        .dir_up        (dir_up),
        .dir_down      (dir_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        call_buttons  = '0;
        current_floor = '0;
        door_open     = 1'b0;
        moving_up     = 1'b0;
        moving_down   = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({floor_buttons, pending, door_open_req, dir_up, dir_down} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got fb=%h pend=%h req=%b up=%b dn=%b, want all 0",
                     floor_buttons, pending, door_open_req, dir_up, dir_down);
        end
    endtask

    task automatic test_first_call();
        apply_reset();
        current_floor = 4'd0;
        call_buttons  = 16'h0020;
        step(1);
        call_buttons = '0;
        step(1);
        checks++;
        if (pending !== 16'h0000) begin
            errors++;
            $display("FAIL latency_early: pending=%h, want 0000", pending);
        end
        step(1);
        checks++;
        if (pending !== 16'h0020 || dir_up !== 1'b0) begin
            errors++;
            $display("FAIL latency_3: pending=%h up=%b, want 0020 0", pending, dir_up);
        end
        step(1);
        checks++;
        if (dir_up !== 1'b1 || dir_down !== 1'b0 || floor_buttons !== 16'h0000) begin
            errors++;
            $display("FAIL dir_up_set: up=%b dn=%b fb=%h, want 1 0 0000",
                     dir_up, dir_down, floor_buttons);
        end
        step(1);
        checks++;
        if (floor_buttons !== 16'h0020) begin
            errors++;
            $display("FAIL first_target: fb=%h, want 0020", floor_buttons);
        end
    endtask

    task automatic test_scan_dwell();
        apply_reset();
        current_floor = 4'd4;
        call_buttons  = 16'h0284;
        step(1);
        call_buttons = '0;
        step(4);
        checks++;
        if (floor_buttons !== 16'h0080 || dir_up !== 1'b1) begin
            errors++;
            $display("FAIL scan_up_target: fb=%h up=%b, want 0080 1", floor_buttons, dir_up);
        end
        current_floor = 4'd7;
        door_open     = 1'b1;
        step(1);
        checks++;
        if (pending !== 16'h0204) begin
            errors++;
            $display("FAIL arrival_clear: pending=%h, want 0204", pending);
        end
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step(1);
            checks++;
            if (floor_buttons !== 16'h0000) begin
                errors++;
                $display("FAIL dwell_mask[%0d]: fb=%h, want 0000", k, floor_buttons);
            end
        end
        step(1);
        checks++;
        if (floor_buttons !== 16'h0200) begin
            errors++;
            $display("FAIL dwell_release: fb=%h, want 0200", floor_buttons);
        end
        door_open = 1'b0;
        step(1);
    endtask

    // Continues from test_scan_dwell: pending {2,9}, going up from floor 7.
    task automatic test_reversal();
        moving_up     = 1'b1;
        current_floor = 4'd9;
        door_open     = 1'b1;
        step(2);
        checks++;
        if (pending !== 16'h0004 || dir_up !== 1'b1) begin
            errors++;
            $display("FAIL reverse_hold: pending=%h up=%b, want 0004 1", pending, dir_up);
        end
        door_open = 1'b0;
        step(3);
        checks++;
        if (dir_up !== 1'b1 || floor_buttons !== 16'h0000) begin
            errors++;
            $display("FAIL reverse_blocked: up=%b fb=%h, want 1 0000", dir_up, floor_buttons);
        end
        moving_up = 1'b0;
        step(1);
        checks++;
        if (dir_down !== 1'b1 || dir_up !== 1'b0 || floor_buttons !== 16'h0000) begin
            errors++;
            $display("FAIL reverse_dir: up=%b dn=%b fb=%h, want 0 1 0000",
                     dir_up, dir_down, floor_buttons);
        end
        step(1);
        checks++;
        if (floor_buttons !== 16'h0004) begin
            errors++;
            $display("FAIL reverse_target: fb=%h, want 0004", floor_buttons);
        end
    endtask

    task automatic test_door_request();
        apply_reset();
        current_floor = 4'd3;
        call_buttons  = 16'h0008;
        step(1);
        call_buttons = '0;
        step(2);
        checks++;
        if (pending !== 16'h0008 || door_open_req !== 1'b0) begin
            errors++;
            $display("FAIL local_pending: pending=%h req=%b, want 0008 0", pending, door_open_req);
        end
        step(1);
        checks++;
        if (door_open_req !== 1'b1 || floor_buttons !== 16'h0000 || dir_up !== 1'b0
            || dir_down !== 1'b0) begin
            errors++;
            $display("FAIL door_req_set: req=%b fb=%h up=%b dn=%b, want 1 0000 0 0",
                     door_open_req, floor_buttons, dir_up, dir_down);
        end
        door_open = 1'b1;
        step(1);
        checks++;
        if (pending !== 16'h0000 || door_open_req !== 1'b0) begin
            errors++;
            $display("FAIL door_req_clear: pending=%h req=%b, want 0000 0", pending, door_open_req);
        end
        call_buttons = 16'h0008;
        step(1);
        call_buttons = '0;
        step(5);
        door_open = 1'b0;
        step(3);
        checks++;
        if (pending !== 16'h0000 || door_open_req !== 1'b0) begin
            errors++;
            $display("FAIL press_while_open: pending=%h req=%b, want 0000 0",
                     pending, door_open_req);
        end
    endtask

    task automatic test_held_button();
        apply_reset();
        current_floor = 4'd0;
        call_buttons  = 16'h0400;
        step(3);
        checks++;
        if (pending !== 16'h0400) begin
            errors++;
            $display("FAIL held_set: pending=%h, want 0400", pending);
        end
        current_floor = 4'd10;
        door_open     = 1'b1;
        step(2);
        door_open = 1'b0;
        step(10);
        checks++;
        if (pending !== 16'h0000 || floor_buttons !== 16'h0000 || dir_up !== 1'b0) begin
            errors++;
            $display("FAIL held_no_reset: pending=%h fb=%h up=%b, want 0000 0000 0",
                     pending, floor_buttons, dir_up);
        end
        call_buttons = '0;
        step(3);
        call_buttons = 16'h0400;
        step(3);
        checks++;
        if (pending !== 16'h0400) begin
            errors++;
            $display("FAIL held_new_edge: pending=%h, want 0400", pending);
        end
        step(1);
        checks++;
        if (door_open_req !== 1'b1) begin
            errors++;
            $display("FAIL held_door_req: req=%b, want 1", door_open_req);
        end
        call_buttons = '0;
    endtask

    task automatic test_reset_mid_move();
        apply_reset();
        current_floor = 4'd4;
        call_buttons  = 16'h1042;
        step(1);
        call_buttons = '0;
        step(4);
        checks++;
        if (floor_buttons !== 16'h0040 || pending !== 16'h1042) begin
            errors++;
            $display("FAIL pre_reset: fb=%h pending=%h, want 0040 1042", floor_buttons, pending);
        end
        moving_up = 1'b1;
        step(2);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({floor_buttons, pending, door_open_req, dir_up, dir_down} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset: fb=%h pend=%h req=%b up=%b dn=%b, want all 0",
                     floor_buttons, pending, door_open_req, dir_up, dir_down);
        end
        step(1);
        reset     = 1'b0;
        moving_up = 1'b0;
        step(10);
        checks++;
        if (floor_buttons !== 16'h0000 || pending !== 16'h0000 || dir_up !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_quiet: fb=%h pending=%h up=%b, want 0000 0000 0",
                     floor_buttons, pending, dir_up);
        end
    endtask

    initial begin
        reset         = 1'b1;
        call_buttons  = '0;
        current_floor = '0;
        door_open     = 1'b0;
        moving_up     = 1'b0;
        moving_down   = 1'b0;
        test_reset();
        test_first_call();
        test_scan_dwell();
        test_reversal();
        test_door_request();
        test_held_button();
        test_reset_mid_move();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
